// File: rtl/serial_bit_feeder_pkg.sv
// Shared types and defaults for the serial bit feeder.
// The optional replay feature is enabled by defining SERIAL_FEEDER_REPEAT_EN.
package serial_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIV   = 1;

  // Counter width that stays at least one bit even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Pattern-load / serial-bit bus between a pattern source and the feeder.
// The loop request exists only when SERIAL_FEEDER_REPEAT_EN is defined.
interface serial_bit_feeder_if
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] load_data;
  logic             start;
`ifdef SERIAL_FEEDER_REPEAT_EN
  logic             loop;
`endif
  logic             w_out;
  logic             w_valid;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;

  modport master (
`ifdef SERIAL_FEEDER_REPEAT_EN
    output loop,
`endif
    output load_data, start,
    input  w_out, w_valid, busy, done, bit_idx
  );

  modport slave (
`ifdef SERIAL_FEEDER_REPEAT_EN
    input  loop,
`endif
    input  load_data, start,
    output w_out, w_valid, busy, done, bit_idx
  );

endinterface

// File: rtl/serial_bit_feeder_bit_tick_divider.sv
// Bit-period divider: counts 0..DIV-1 and flags the last cycle of each period.
// Saturates at the terminal count until cleared, so it never wraps on its own.
module bit_tick_divider
  import serial_feeder_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  output logic tick
);
  localparam int                 DIV_W = cnt_width(DIV);
  localparam logic [DIV_W-1:0]   LAST  = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (div_cnt != LAST) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/serial_bit_feeder.sv
// Loads a parallel pattern and shifts it out LSB-first, one bit per DIV cycles.
// Define SERIAL_FEEDER_REPEAT_EN to add the loop input and back-to-back replay.
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input logic                clk,
  input logic                resetn,
  serial_bit_feeder_if.slave bus
);
  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] bit_cnt;
  logic             tick;
`ifdef SERIAL_FEEDER_REPEAT_EN
  logic [WIDTH-1:0] hold;
`endif

  // The divider restarts whenever a bit period begins: on accept and after every sampled bit.
  bit_tick_divider #(.DIV(DIV)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .clr    ((state != SHIFT) || tick),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef SERIAL_FEEDER_REPEAT_EN
      hold    <= '0;
`endif
    end else begin
      // NOTE: a default arm keeps the decode total, so no illegal code can stick.
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.load_data;
            bit_cnt <= '0;
            state   <= SHIFT;
`ifdef SERIAL_FEEDER_REPEAT_EN
            hold    <= bus.load_data;
`endif
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bit_cnt != LAST_BIT) begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + IDX_W'(1);
            end else begin
`ifdef SERIAL_FEEDER_REPEAT_EN
              if (bus.loop) begin
                shreg   <= hold;
                bit_cnt <= '0;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; reset clears them without a clock.
  assign bus.busy    = (state == SHIFT);
  assign bus.w_out   = (state == SHIFT) && shreg[0];
  assign bus.w_valid = (state == SHIFT) && tick;
  assign bus.bit_idx = (state == SHIFT) ? bit_cnt : '0;
  assign bus.done    = (state == DONE);

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

- Upstream stage of the one-hot sequence-detector FSM.
- Loads a parallel test word, then shifts it out LSB-first, one bit per bit period, on `w_out`.
- `w_valid` marks the sampling cycle of each bit; the detector uses it as its clock enable and `w_out` as its `W` input.
- Lets a whole pattern be replayed into the detector from switches without hand-stepping a key per bit.

## Interface
- `WIDTH`, 16: number of bits in the pattern word; legal range is 2 or more.
- `DIV`, 1: clock cycles per bit period; legal range is 1 or more.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `load_data`  in  WIDTH  pattern word, sampled only on the accepting edge of `start`.
- `start`  in  1  level request; accepted only in IDLE.
- `loop`  in  1  present only when `SERIAL_FEEDER_REPEAT_EN` is defined.
- `w_out`  out  1  current serial bit; 0 outside SHIFT.
- `w_valid`  out  1  high on the last cycle of each bit period.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse after the final bit.
- `bit_idx`  out  $clog2(WIDTH)  index of the bit currently on `w_out`.

## Operation
- Three-state FSM: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 at an edge: `shreg`<=`load_data`, `bit_cnt`<=0, `div_cnt`<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - `w_out`=`shreg[0]`; `bit_idx`=`bit_cnt`.
  - `div_cnt` counts 0..DIV-1; `w_valid`=(`div_cnt`==DIV-1).
  - On a `w_valid` edge with `bit_cnt`<WIDTH-1: `shreg`>>1, `bit_cnt`+1, `div_cnt`<=0.
  - On a `w_valid` edge with `bit_cnt`==WIDTH-1: go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored in SHIFT and DONE; it is never queued.
- With `start` held high, the block re-accepts on the first IDLE edge: one idle cycle between runs.
- Counter and shift widths:
  - `bit_cnt` is $clog2(WIDTH) bits and never exceeds WIDTH-1.
  - `div_cnt` is max(1,$clog2(DIV)) bits.
  - No wrap-around beyond the terminal values.
- Asynchronous reset (`resetn`=0), including mid-shift:
  - State goes to IDLE immediately.
  - `shreg`, `bit_cnt`, `div_cnt` go to 0.
  - All outputs go to 0 without waiting for a clock edge.
  - The aborted word is discarded; no `done` is produced.

## Timing
- Reset value of every output is 0: `w_out`, `w_valid`, `busy`, `done`, `bit_idx`.
- Accept edge E0: bit 0 appears on `w_out` in the cycle after E0.
- Bit k occupies cycles E0+1+k·DIV through E0+(k+1)·DIV.
- `w_valid` is high in cycle E0+(k+1)·DIV.
- `done` is high in cycle E0+WIDTH·DIV+1.
- IDLE is re-entered after edge E0+WIDTH·DIV+1.
- The earliest next accept is at edge E0+WIDTH·DIV+2.
- All outputs are registered-state decodes; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_FEEDER_REPEAT_EN` defined:
  - The `loop` port exists.
  - If `loop`=1 on the final `w_valid` edge, the FSM reloads the originally captured word into `shreg` (a second register holds it).
  - It then resets `bit_cnt`/`div_cnt` and stays in SHIFT, so bit 0 follows bit WIDTH-1 with no gap.
  - No `done` is produced in that case; `done` fires only on the final bit of the run in which `loop`=0.
- Undefined: no `loop` port and no hold register; every run is single-shot.

## Structure
- Package `serial_feeder_pkg`:
  - State encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default `WIDTH`/`DIV` values.
- One sub-module `bit_tick_divider`:
  - Holds `div_cnt` and emits the `tick` that drives `w_valid`.
  - Cleared by a synchronous `clr` on accept/advance, and by the async `resetn`.
- Top module holds the FSM, `shreg`, `bit_cnt` and, under the macro, the hold register.

## Test plan
- WIDTH=8, DIV=1, `load_data`=8'b0110_1101, one-cycle `start`:
  - `w_out` = 1,0,1,1,0,1,1,0 over cycles 1-8, with `w_valid` high in each.
  - `done` high in cycle 9 only; `busy` low from cycle 9.
- WIDTH=4, DIV=3, `load_data`=4'b1010:
  - Each bit held 3 cycles; `w_valid` only in cycles 3, 6, 9, 12.
  - `done` in cycle 13.
- Pulse `start` again at cycle 4 with `load_data`=8'hFF during the 8'h6D run:
  - Output sequence unchanged.
  - Exactly one `done`, at cycle 9.
- Drop `resetn` asynchronously mid-cycle at bit 3:
  - All outputs 0 before the next edge; no `done`.
  - After release, a new `start` replays from bit 0.
- Hold `start` high continuously, WIDTH=4, DIV=1:
  - Runs separated by exactly one IDLE cycle after each `done`.
- `SERIAL_FEEDER_REPEAT_EN`, WIDTH=4, `loop`=1 for two passes then 0:
  - `w_out` pattern repeats 3 times back-to-back.
  - A single `done` after the 12th bit.
